// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave with ready/valid word output, overrun and frame-error pulses.
// Optional MISO transmit path enabled by defining SPI_SLAVE_RX_MISO_EN.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
`ifdef SPI_SLAVE_RX_MISO_EN
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;
    logic [1:0]             settle_r;
    logic                   armed_r;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_next_s;
    logic [DATA_W-1:0]      shift_r;
    logic [DATA_W-1:0]      shift_next_s;
    logic [DATA_W-1:0]      rx_data_r;
    logic [DATA_W-1:0]      rx_data_next_s;
    logic                   rx_valid_r;
    logic                   rx_valid_next_s;
    logic                   overrun_r;
    logic                   overrun_next_s;
    logic                   frame_err_r;
    logic                   frame_err_next_s;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   re_s;
    logic                   fe_s;
    logic                   settled_s;
    logic                   enter_s;
    logic                   leave_s;
    logic                   shift_en_s;
    logic                   last_bit_s;
    logic                   commit_s;
    logic                   handshake_s;
    logic [DATA_W-1:0]      word_s;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign re_s        = sclk_s & ~sclk_prev_r;
    assign fe_s        = ~sclk_s & sclk_prev_r;
    assign settled_s   = (settle_r == 2'(SYNC_STAGES));
    assign enter_s     = (state_r == IDLE) && (state_next_s == ACTIVE);
    assign leave_s     = (state_r == ACTIVE) && (state_next_s == IDLE);
    assign shift_en_s  = (state_r == ACTIVE) && !cs_s && re_s;
    assign last_bit_s  = (cnt_r == CNT_W'(DATA_W - 1));
    assign commit_s    = shift_en_s && last_bit_s;
    assign handshake_s = rx_valid_r && rx_ready;
    assign word_s      = {shift_r[DATA_W-2:0], mosi_s};

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign overrun     = overrun_r;
    assign frame_err   = frame_err_r;

    // Input synchronizers and sclk edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            sclk_prev_r <= sclk_s;
        end
    end

    // After reset, wait for the synchronizer to hold a real cs_n sample and then for
    // cs_n high, so a frame already in progress at reset release is never picked up.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_r <= 2'd0;
            armed_r  <= 1'b0;
        end else begin
            if (!settled_s) begin
                settle_r <= settle_r + 2'd1;
            end else begin
                settle_r <= settle_r;
            end
            armed_r <= armed_r | (settled_s & cs_s);
        end
    end

    // FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!cs_s && armed_r) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Bit counter, shift register and output word handling.
    always_comb begin
        cnt_next_s       = cnt_r;
        shift_next_s     = shift_r;
        rx_data_next_s   = rx_data_r;
        rx_valid_next_s  = rx_valid_r;
        overrun_next_s   = 1'b0;
        frame_err_next_s = leave_s && (cnt_r != {CNT_W{1'b0}});

        if (enter_s || leave_s) begin
            cnt_next_s   = {CNT_W{1'b0}};
            shift_next_s = {DATA_W{1'b0}};
        end else if (shift_en_s) begin
            shift_next_s = word_s;
            if (last_bit_s) begin
                cnt_next_s = {CNT_W{1'b0}};
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s   = cnt_r;
            shift_next_s = shift_r;
        end

        // A commit that coincides with a handshake replaces the word instead of dropping it.
        if (commit_s) begin
            if (rx_valid_r && !rx_ready) begin
                overrun_next_s = 1'b1;
            end else begin
                rx_data_next_s  = word_s;
                rx_valid_next_s = 1'b1;
            end
        end else if (handshake_s) begin
            rx_valid_next_s = 1'b0;
        end else begin
            rx_valid_next_s = rx_valid_r;
        end
    end

    // Receive state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shift_r     <= {DATA_W{1'b0}};
            rx_data_r   <= {DATA_W{1'b0}};
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            shift_r     <= shift_next_s;
            rx_data_r   <= rx_data_next_s;
            rx_valid_r  <= rx_valid_next_s;
            overrun_r   <= overrun_next_s;
            frame_err_r <= frame_err_next_s;
        end
    end

`ifdef SPI_SLAVE_RX_MISO_EN
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] tx_next_s;
    logic              skip_fe_r;
    logic              skip_fe_next_s;
    logic              miso_r;
    logic              miso_next_s;

    assign miso = miso_r;

    // Transmit shifter. The reload at a commit happens on the last rising edge, so the
    // falling edge right after it must not shift or the new word would lose its MSB.
    always_comb begin
        tx_next_s      = tx_r;
        skip_fe_next_s = skip_fe_r;
        if (enter_s) begin
            tx_next_s      = tx_data;
            skip_fe_next_s = 1'b0;
        end else if (commit_s) begin
            tx_next_s      = tx_data;
            skip_fe_next_s = 1'b1;
        end else if ((state_r == ACTIVE) && !cs_s && fe_s) begin
            if (skip_fe_r) begin
                skip_fe_next_s = 1'b0;
            end else begin
                tx_next_s = {tx_r[DATA_W-2:0], 1'b0};
            end
        end else begin
            tx_next_s = tx_r;
        end
        if (state_next_s == ACTIVE) begin
            miso_next_s = tx_next_s[DATA_W-1];
        end else begin
            miso_next_s = 1'b0;
        end
    end

    // Transmit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r      <= {DATA_W{1'b0}};
            skip_fe_r <= 1'b0;
            miso_r    <= 1'b0;
        end else begin
            tx_r      <= tx_next_s;
            skip_fe_r <= skip_fe_next_s;
            miso_r    <= miso_next_s;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed self-checking bench for spi_slave_rx (DATA_W=8, SYNC_STAGES=2), sclk at f_clk/8.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
`ifdef SPI_SLAVE_RX_MISO_EN
    logic [7:0] tx_data = 8'h00;
    logic       miso;
`endif

    int         tests_run = 0;
    int         tests_failed = 0;
    int         n_ovr = 0;
    int         n_ferr = 0;
    logic [7:0] hs_q[$];
    logic [7:0] miso_word = 8'h00;

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
`ifdef SPI_SLAVE_RX_MISO_EN
        .tx_data   (tx_data),
        .miso      (miso),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Event monitor on the inactive edge: pulse counts and accepted words.
    always @(negedge clk) begin
        if (overrun) n_ovr++;
        if (frame_err) n_ferr++;
        if (rx_valid && rx_ready) hs_q.push_back(rx_data);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        wait_clk(4);
`ifdef SPI_SLAVE_RX_MISO_EN
        miso_word = {miso_word[6:0], miso};
`endif
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) spi_bit(w[i]);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        tests_run++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b data=%h ovr=%b ferr=%b, want 0/00/0/0",
                     rx_valid, rx_data, overrun, frame_err);
        end
`ifdef SPI_SLAVE_RX_MISO_EN
        tests_run++;
        if (miso !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_miso: got %b want 0", miso);
        end
`endif
        rst = 1'b0;
        wait_clk(4);
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_valid: got %b want 0", rx_valid);
        end
    endtask

    task automatic test_single();
        int ovr0, ferr0, hs0;
        ovr0 = n_ovr; ferr0 = n_ferr; hs0 = hs_q.size();
        rx_ready = 1'b0;
        cs_low();
        send_bits(8'hA5, 8);
        cs_high();
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_word: valid=%b data=%h, want 1/a5", rx_valid, rx_data);
        end
        tests_run++;
        if (n_ovr != ovr0 || n_ferr != ferr0) begin
            tests_failed++;
            $display("FAIL single_flags: ovr=%0d ferr=%0d, want 0/0", n_ovr - ovr0, n_ferr - ferr0);
        end
        drain();
        tests_run++;
        if (rx_valid !== 1'b0 || hs_q.size() != hs0 + 1) begin
            tests_failed++;
            $display("FAIL single_consume: valid=%b handshakes=%0d, want 0/1", rx_valid, hs_q.size() - hs0);
        end
    endtask

    task automatic test_back_to_back();
        int hs0;
        hs0 = hs_q.size();
        rx_ready = 1'b1;
        cs_low();
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        cs_high();
        rx_ready = 1'b0;
        tests_run++;
        if (hs_q.size() != hs0 + 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d handshakes want 2", hs_q.size() - hs0);
        end else begin
            tests_run++;
            if (hs_q[hs0] !== 8'h3C || hs_q[hs0+1] !== 8'hC3) begin
                tests_failed++;
                $display("FAIL b2b_data: got %h,%h want 3c,c3", hs_q[hs0], hs_q[hs0+1]);
            end
        end
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_valid: got %b want 0", rx_valid);
        end
    endtask

    task automatic test_overrun();
        int ovr0;
        ovr0 = n_ovr;
        rx_ready = 1'b0;
        cs_low();
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        cs_high();
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL overrun_keep: valid=%b data=%h want 1/11", rx_valid, rx_data);
        end
        tests_run++;
        if (n_ovr != ovr0 + 1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got %0d pulses want 1", n_ovr - ovr0);
        end
        drain();
    endtask

    task automatic test_frame_err();
        int ferr0;
        ferr0 = n_ferr;
        cs_low();
        send_bits(8'hF8, 5);
        cs_high();
        tests_run++;
        if (n_ferr != ferr0 + 1 || rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_err_pulse: pulses=%0d valid=%b want 1/0", n_ferr - ferr0, rx_valid);
        end
        cs_low();
        send_bits(8'h7E, 8);
        cs_high();
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h7E || n_ferr != ferr0 + 1) begin
            tests_failed++;
            $display("FAIL frame_err_recover: valid=%b data=%h pulses=%0d want 1/7e/1",
                     rx_valid, rx_data, n_ferr - ferr0);
        end
        drain();
    endtask

    task automatic test_reset_midframe();
        int ferr0;
        ferr0 = n_ferr;
        cs_low();
        send_bits(8'hFF, 4);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        send_bits(8'hFF, 8);
        tests_run++;
        if (rx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held_cs: valid=%b want 0 (frame open across reset)", rx_valid);
        end
        cs_high();
        cs_low();
        send_bits(8'h81, 8);
        cs_high();
        tests_run++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
            tests_failed++;
            $display("FAIL reset_mid_data: valid=%b data=%h want 1/81", rx_valid, rx_data);
        end
        tests_run++;
        if (n_ferr != ferr0) begin
            tests_failed++;
            $display("FAIL reset_mid_ferr: got %0d pulses want 0", n_ferr - ferr0);
        end
        drain();
    endtask

`ifdef SPI_SLAVE_RX_MISO_EN
    task automatic test_miso();
        tx_data = 8'h96;
        wait_clk(2);
        tests_run++;
        if (miso !== 1'b0) begin
            tests_failed++;
            $display("FAIL miso_idle: got %b want 0", miso);
        end
        cs_low();
        miso_word = 8'h00;
        send_bits(8'h00, 8);
        cs_high();
        tests_run++;
        if (miso_word !== 8'h96) begin
            tests_failed++;
            $display("FAIL miso_word: got %h want 96", miso_word);
        end
        tests_run++;
        if (miso !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL miso_after: miso=%b data=%h valid=%b want 0/00/1", miso, rx_data, rx_valid);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_reset_midframe();
`ifdef SPI_SLAVE_RX_MISO_EN
        test_miso();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
